// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction memory.
//   DEPTH_WORDS   - default number of 32-bit words (power of two, >= 24)
//   NOP_WORD      - addi x0,x0,0; padding and out-of-range read value
//   PROG_WORDS    - number of leading words that hold the boot program
//   DEFAULT_IMAGE - contents loaded on reset
//   word_index()  - byte address -> word index plus in-range flag
//   image_word()  - reset value of one word for an arbitrary depth/NOP choice
package imem_pkg;

   localparam int unsigned DEPTH_WORDS = 64;
   localparam int unsigned PROG_WORDS  = 24;
   localparam int unsigned IMAGE_AW    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

   typedef logic [31:0] image_t [DEPTH_WORDS];

   localparam image_t DEFAULT_IMAGE = '{
      0:  32'h0050_0093,  // addi x1,x0,5
      1:  32'h00A0_0113,  // addi x2,x0,10
      2:  32'h0020_81B3,  // add  x3,x1,x2
      3:  32'h4011_0233,  // sub  x4,x2,x1
      4:  32'h0020_F2B3,  // and  x5,x1,x2
      5:  32'h0020_E333,  // or   x6,x1,x2
      6:  32'h0020_C3B3,  // xor  x7,x1,x2
      7:  32'h0020_A433,  // slt  x8,x1,x2
      8:  32'h0030_2023,  // sw   x3,0(x0)
      9:  32'h0000_2483,  // lw   x9,0(x0)
      10: 32'hFFF4_8513,  // addi x10,x9,-1
      11: 32'h0005_0463,  // beq  x10,x0,+8
      12: 32'h0010_0593,  // addi x11,x0,1
      13: 32'h00C0_0613,  // addi x12,x0,12
      14: 32'h00D0_0693,  // addi x13,x0,13
      15: 32'h00E0_0713,  // addi x14,x0,14
      16: 32'h00F0_0793,  // addi x15,x0,15
      17: 32'h0100_0813,  // addi x16,x0,16
      18: 32'h0110_0893,  // addi x17,x0,17
      19: 32'h0120_0913,  // addi x18,x0,18
      20: 32'h0130_0993,  // addi x19,x0,19
      21: 32'h0140_0A13,  // addi x20,x0,20
      22: 32'h0150_0A93,  // addi x21,x0,21
      23: 32'h0000_006F,  // jal  x0,0 (park here)
      default: NOP_WORD
   };

   typedef struct packed {
      logic [29:0] idx;
      logic        ok;
   } word_index_t;

   // Full 30-bit index is compared so high PC bits never alias into the array.
   function automatic word_index_t word_index(input logic [31:0] addr,
                                              input int unsigned depth);
      word_index_t r;
      r.idx = addr[31:2];
      r.ok  = ({2'b00, addr[31:2]} < depth);
      return r;
   endfunction

   function automatic logic [31:0] image_word(input int unsigned i,
                                              input logic [31:0] nop);
      logic [IMAGE_AW-1:0] k;
      k = i[IMAGE_AW-1:0];
      return (i < PROG_WORDS) ? DEFAULT_IMAGE[k] : nop;
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction memory with combinational read and a synchronous
// write port. A synchronous reset reloads the whole default program image.
//   clk        - rising-edge clock for writes and reset
//   rst        - synchronous active-high; reloads the default image
//   PC         - byte address to fetch
//   Instr      - word at PC>>2, or NOP_WORD when out of range (combinational)
//   misaligned - PC[1:0] != 0; informational only, fetch still uses PC>>2
//   we         - write enable
//   waddr      - byte address of the word to write (low two bits ignored)
//   wdata      - word to write
module instruction_memory #(
   parameter int unsigned DEPTH_WORDS = imem_pkg::DEPTH_WORDS,
   parameter logic [31:0] NOP_WORD    = imem_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   output logic [31:0] Instr,
   input  logic        we,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   output logic        misaligned
);
   import imem_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0] mem_q [DEPTH_WORDS];

   word_index_t ridx;
   word_index_t widx;

   assign ridx = word_index(PC, DEPTH_WORDS);
   assign widx = word_index(waddr, DEPTH_WORDS);

   // Upper index bits only matter through the in-range flag.
   logic unused_idx;
   assign unused_idx = ^{ridx.idx[29:AW], widx.idx[29:AW]};

   // Reset wins over a same-cycle write; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= image_word(i, NOP_WORD);
         end
      end else if (we && widx.ok) begin
         mem_q[widx.idx[AW-1:0]] <= wdata;
      end
   end

   // No write bypass: a read of the word being written shows the old value.
   always_comb begin
      Instr = NOP_WORD;
      if (ridx.ok) begin
         Instr = mem_q[ridx.idx[AW-1:0]];
      end
   end

   assign misaligned = |PC[1:0];

endmodule

// File: tb/tb_instruction_memory.sv
module tb_instruction_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        misaligned;

   int tests = 0;
   int fails = 0;

   instruction_memory dut (
      .clk        (clk),
      .rst        (rst),
      .PC         (PC),
      .Instr      (Instr),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } vec_t;

   logic [31:0] img [24];
   vec_t        vecs [$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Apply every vector; word at patch_pc (if patched) is expected as patch_val.
   task automatic run_table(input string tag, input bit patched,
                            input logic [31:0] patch_pc, input logic [31:0] patch_val);
      logic [31:0] exp;
      foreach (vecs[i]) begin
         PC = vecs[i].pc;
         #1;
         exp = vecs[i].instr;
         if (patched && (vecs[i].pc[31:2] == patch_pc[31:2])) exp = patch_val;
         check32($sformatf("%s instr pc=%h", tag, vecs[i].pc), Instr, exp);
         check1($sformatf("%s misaligned pc=%h", tag, vecs[i].pc), misaligned, vecs[i].mis);
         #4;
      end
   endtask

   initial begin
      img[0]  = 32'h0050_0093; img[1]  = 32'h00A0_0113; img[2]  = 32'h0020_81B3;
      img[3]  = 32'h4011_0233; img[4]  = 32'h0020_F2B3; img[5]  = 32'h0020_E333;
      img[6]  = 32'h0020_C3B3; img[7]  = 32'h0020_A433; img[8]  = 32'h0030_2023;
      img[9]  = 32'h0000_2483; img[10] = 32'hFFF4_8513; img[11] = 32'h0005_0463;
      img[12] = 32'h0010_0593; img[13] = 32'h00C0_0613; img[14] = 32'h00D0_0693;
      img[15] = 32'h00E0_0713; img[16] = 32'h00F0_0793; img[17] = 32'h0100_0813;
      img[18] = 32'h0110_0893; img[19] = 32'h0120_0913; img[20] = 32'h0130_0993;
      img[21] = 32'h0140_0A13; img[22] = 32'h0150_0A93; img[23] = 32'h0000_006F;

      for (int i = 0; i < 24; i++) vecs.push_back('{32'(i * 4), img[i], 1'b0});
      vecs.push_back('{32'd2,          32'h0050_0093, 1'b1});
      vecs.push_back('{32'd5,          32'h00A0_0113, 1'b1});
      vecs.push_back('{32'd96,         32'h0000_0013, 1'b0});  // first padding word
      vecs.push_back('{32'd252,        32'h0000_0013, 1'b0});  // last in-range word
      vecs.push_back('{32'd256,        32'h0000_0013, 1'b0});  // first out-of-range
      vecs.push_back('{32'hFFFF_FFFC,  32'h0000_0013, 1'b0});
      vecs.push_back('{32'h0000_0100 | 32'h8, 32'h0000_0013, 1'b0});  // no wrap to word 2

      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; PC = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_table("reset", 1'b0, '0, '0);

      // Write word 3; old value holds until the edge.
      @(negedge clk);
      PC = 32'd12; we = 1'b1; waddr = 32'd12; wdata = 32'hDEAD_BEEF;
      #1;
      check32("write pre-edge", Instr, 32'h4011_0233);
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      check32("write post-edge", Instr, 32'hDEAD_BEEF);

      // Misaligned write address lands on the same word.
      @(negedge clk);
      PC = 32'd16; we = 1'b1; waddr = 32'd17; wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      check32("misaligned waddr", Instr, 32'hCAFE_F00D);
      @(negedge clk);
      we = 1'b1; waddr = 32'd16; wdata = img[4];
      @(posedge clk); #1;
      we = 1'b0;

      // Out-of-range write must not alias anywhere.
      @(negedge clk);
      we = 1'b1; waddr = 32'd256; wdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      we = 1'b0;
      run_table("oor-write", 1'b1, 32'd12, 32'hDEAD_BEEF);

      // Reset beats a same-cycle write and restores the patched word.
      @(negedge clk);
      rst = 1'b1; we = 1'b1; waddr = 32'd0; wdata = 32'h1234_5678;
      @(posedge clk); #1;
      rst = 1'b0; we = 1'b0; PC = 32'd0;
      #1;
      check32("rst over we", Instr, 32'h0050_0093);
      PC = 32'd12;
      #1;
      check32("reset restores word3", Instr, 32'h4011_0233);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Word-organised instruction memory for the RISC-V single-cycle processor; sits between the PC register and the decoder/control path.
- Read is combinational, so the instruction for the current PC is available in the same cycle.
- Contents are a register array initialised from a default program image on reset.
- A synchronous write port allows a bench or loader to overwrite words.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words; must be a power of two ≥ 24.
- NOP_WORD, 32'h0000_0013, value returned for out-of-range reads and used to pad the default image (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock for writes and reset.
- rst  input  1  synchronous, active-high; reloads the default image.
- PC  input  32  byte address of the instruction to fetch.
- Instr  output  32  instruction word at PC; combinational.
- we  input  1  write enable, sampled on the rising clk edge.
- waddr  input  32  byte address of the word to write.
- wdata  input  32  word to write.
- misaligned  output  1  combinational; high when PC[1:0] != 0.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Word index: PC[1:0] is ignored for the access; word index is PC >> 2.
- Read:
  - Instr = mem[PC>>2] when (PC>>2) < DEPTH_WORDS, else NOP_WORD.
  - Purely combinational, no latency; Instr changes in the same delta as PC.
  - misaligned = |PC[1:0]. It is a flag only and the read still proceeds using the truncated address.
- Reset:
  - On a clk edge with rst=1, every word is loaded from DEFAULT_IMAGE in one cycle.
  - The image is: word0 = 32'h0050_0093 (addi x1,x0,5), word1 = 32'h00A0_0113 (addi x2,x0,10), word2 = 32'h0020_81B3 (add x3,x1,x2), word3 = 32'h4011_0233 (sub x4,x2,x1), words 4..23 = program-specific entries from the package, remaining words = NOP_WORD.
  - Instr reflects the reloaded image immediately after that edge.
- Write:
  - On a clk edge with rst=0 and we=1 and (waddr>>2) < DEPTH_WORDS, mem[waddr>>2] <= wdata. waddr[1:0] is ignored.
  - An out-of-range write is silently dropped.
- Priority: rst overrides we in the same cycle; the write is lost.
- Read-during-write: no bypass. A read of the written address returns the old word until the edge, then the new word.
- Before the first reset, contents are undefined. The bench must assert rst for at least one edge before checking Instr.
- Word 0 maps to PC = 0; there is no base-address offset.
- Upper PC bits beyond the index width are not wrapped; they yield NOP_WORD.

Decomposition:
- Package imem_pkg: DEPTH_WORDS default, NOP_WORD constant, and DEFAULT_IMAGE as a constant array of DEPTH_WORDS x 32-bit.
- Package also holds a helper function word_index(addr) returning addr>>2 and an in-range bit.
- No sub-module is needed; a single module with the register array, write process and combinational read mux.

Test Plan:
- Reset then sweep PC = 0,4,...,92 at 5 ns steps: Instr equals DEFAULT_IMAGE[0..23]; PC=0 gives 32'h0050_0093, PC=8 gives 32'h0020_81B3, misaligned=0 throughout.
- PC = 2 and PC = 5: Instr = 32'h0050_0093 and 32'h00A0_0113 respectively (low bits ignored); misaligned = 1 for both.
- Out-of-range: PC = 4*DEPTH_WORDS (256) and PC = 32'hFFFF_FFFC give Instr = 32'h0000_0013.
- Write we=1, waddr=12, wdata=32'hDEAD_BEEF with PC=12: Instr stays 32'h4011_0233 before the edge and reads 32'hDEAD_BEEF after it.
- Simultaneous rst=1 and we=1 to waddr=0 with wdata=32'h1234_5678: after the edge PC=0 gives 32'h0050_0093.
- Write to waddr=256 (out of range) then sweep: all words still match the image; after a later reset, the word previously written at 12 returns 32'h4011_0233.
